// File: rtl/fib_bcd.sv
// -----------------------------------------------------------------------------
// fib_bcd
//
// Converts the Fibonacci engine's binary result to BCD for the display/print
// stage. The value is captured on a start strobe. The shift-add-3 (double
// dabble) algorithm then processes one input bit per clock, so a conversion
// takes W clocks. The start/done handshake matches the engine's, so the
// engine's done rising edge can drive start directly.
//
// Ports
//   clk    in   1              rising-edge clock
//   rst_n  in   1              asynchronous active-low reset
//   start  in   1              conversion request, honoured only while idle
//   bin    in   W              unsigned binary value, captured on accept
//   bcd    out  4*DIGITS       packed BCD result, units digit in [3:0]
//   ndig   out  clog2(DIGITS+1) significant decimal digits (1..DIGITS)
//   valid  out  1              one-cycle pulse when bcd/ndig update
//   done   out  1              high while idle, low while converting
//
// State table
//   state | meaning
//   IDLE  | waiting for start; bcd/ndig hold the last result
//   CONV  | shifting one bit per clock; cnt counts remaining shifts
// -----------------------------------------------------------------------------
module fib_bcd #(
    parameter int W      = 32,
    parameter int DIGITS = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [W-1:0]                 bin,
    output logic [4*DIGITS-1:0]          bcd,
    output logic [$clog2(DIGITS+1)-1:0]  ndig,
    output logic                         valid,
    output logic                         done
);

    localparam int CW = $clog2(W + 1);
    localparam int NW = $clog2(DIGITS + 1);
    localparam int BW = 4 * DIGITS;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    sr;
    logic [BW-1:0]   acc;

    logic [BW-1:0]   acc_adj;
    logic [BW-1:0]   acc_shift;
    logic [NW-1:0]   ndig_c;

    // Every digit is corrected in parallel, before the shift. A digit >= 5
    // would become >= 10 after doubling, so adding 3 first makes the carry
    // land in the next digit. Given the DIGITS constraint a digit never
    // exceeds 9 after a shift, so the 4-bit add cannot wrap.
    always_comb begin
        acc_adj = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5)
                acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            else
                acc_adj[4*d +: 4] = acc[4*d +: 4];
        end
    end

    // The MSB of the binary shift register feeds bit 0 of the BCD scratch.
    assign acc_shift = {acc_adj[BW-2:0], sr[W-1]};

    // Count of significant digits in the value about to be committed. The
    // ascending scan keeps the highest nonzero digit. An all-zero result
    // still reports one digit, so the printer always emits "0".
    always_comb begin
        ndig_c = NW'(1);
        for (int d = 0; d < DIGITS; d++) begin
            if (acc_shift[4*d +: 4] != 4'd0)
                ndig_c = NW'(d + 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
            acc   <= '0;
            bcd   <= '0;
            ndig  <= '0;
            valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid <= 1'b0;
                    if (start) begin
                        sr    <= bin;
                        acc   <= '0;
                        cnt   <= CW'(W);
                        state <= CONV;
                    end
                end
                CONV: begin
                    acc   <= acc_shift;
                    sr    <= {sr[W-2:0], 1'b0};
                    cnt   <= cnt - CW'(1);
                    valid <= 1'b0;
                    if (cnt == CW'(1)) begin
                        bcd   <= acc_shift;
                        ndig  <= ndig_c;
                        valid <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    valid <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // done is decoded from the registered state. It falls on the accepting
    // edge, which lets the engine see the handshake without an extra cycle.
    assign done = (state == IDLE);

endmodule

// File: tb/tb_fib_bcd.sv
// -----------------------------------------------------------------------------
// tb_fib_bcd
//
// Self-checking bench for fib_bcd (W=32, DIGITS=10). Whenever the bench
// launches a conversion it pushes the expected BCD and digit count, computed
// by repeated decimal division, into a queue. A monitor pops one entry per
// valid pulse and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_fib_bcd;

    localparam int W      = 32;
    localparam int DIGITS = 10;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [W-1:0]         bin;
    logic [4*DIGITS-1:0]  bcd;
    logic [3:0]           ndig;
    logic                 valid;
    logic                 done;

    int n_checks = 0;
    int n_errors = 0;
    int n_valid  = 0;

    logic [39:0] exp_bcd_q[$];
    logic [3:0]  exp_ndig_q[$];

    fib_bcd #(.W(W), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .bcd   (bcd),
        .ndig  (ndig),
        .valid (valid),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] bcd_model(input longint unsigned v);
        logic [39:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] ndig_model(input longint unsigned v);
        int n;
        n = 1;
        while (v >= 10) begin
            v = v / 10;
            n++;
        end
        return 4'(n);
    endfunction

    task automatic push_exp(input longint unsigned v);
        exp_bcd_q.push_back(bcd_model(v));
        exp_ndig_q.push_back(ndig_model(v));
    endtask

    always @(negedge clk) begin
        if (rst_n && valid) begin
            n_valid++;
            if (exp_bcd_q.size() == 0) begin
                check("valid_unexpected", 64'd1, 64'd0);
            end else begin
                check("bcd", 64'(bcd), 64'(exp_bcd_q.pop_front()));
                check("ndig", 64'(ndig), 64'(exp_ndig_q.pop_front()));
            end
        end
    end

    task automatic wait_idle(input string tag);
        int guard;
        guard = 0;
        while (!done && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!done) check({tag, "_idle_timeout"}, 64'd0, 64'd1);
    endtask

    // One-shot conversion. Checks that done stays low for exactly W cycles
    // and that valid is a single-cycle pulse.
    task automatic convert(input logic [31:0] v, input string tag);
        int lows;
        wait_idle(tag);
        @(negedge clk);
        bin   = v;
        start = 1'b1;
        push_exp(64'(v));
        @(posedge clk);
        #1;
        start = 1'b0;
        bin   = $urandom;
        lows  = 0;
        while (!done && lows < 100) begin
            lows++;
            @(posedge clk);
            #1;
        end
        check({tag, "_done_low"}, 64'(lows), 64'd32);
        check({tag, "_valid"}, 64'(valid), 64'd1);
        @(posedge clk);
        #1;
        check({tag, "_valid_pulse"}, 64'(valid), 64'd0);
    endtask

    initial begin
        int cyc;
        int nv;
        logic [31:0] fa, fb, ft;

        rst_n = 1'b0;
        start = 1'b0;
        bin   = '0;
        #12;
        check("rst_done", 64'(done), 64'd1);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_bcd", 64'(bcd), 64'd0);
        check("rst_ndig", 64'(ndig), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic values, including the boundaries.
        convert(32'd832040, "fib30");
        check("fib30_bcd_const", 64'(bcd), 64'h0000832040);
        check("fib30_ndig_const", 64'(ndig), 64'd6);
        convert(32'd0, "zero");
        convert(32'hFFFF_FFFF, "max");
        check("max_bcd_const", 64'(bcd), 64'h4294967295);
        convert(32'd1, "one");
        convert(32'd4000000000, "r1");
        convert($urandom, "r2");

        // start pulses while a conversion is running must be ignored.
        wait_idle("ign");
        @(negedge clk);
        bin   = 32'd832040;
        start = 1'b1;
        push_exp(64'd832040);
        @(posedge clk);
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            if (c == 3 || c == 20) begin
                start = 1'b1;
                bin   = 32'd5;
            end else begin
                start = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check("ign_done_at_pw", 64'(done), 64'd1);
        convert(32'd5, "after_ign");

        // start held high: back-to-back conversions, W+1 cycles apart.
        wait_idle("held");
        @(negedge clk);
        bin   = 32'd100;
        start = 1'b1;
        push_exp(64'd100);
        push_exp(64'd99);
        @(posedge clk);
        @(negedge clk);
        bin = 32'd99;
        #1;
        cyc = 0;
        while (!done && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("held_first_len", 64'(cyc), 64'd32);
        check("held_valid_coincide", 64'(valid), 64'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("held_reaccept", 64'(done), 64'd0);
        wait_idle("held2");

        // Reset in the middle of a conversion aborts it.
        convert(32'd7, "pre_rst");
        @(negedge clk);
        bin   = 32'd832040;
        start = 1'b1;
        push_exp(64'd832040);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        nv    = n_valid;
        rst_n = 1'b0;
        #1;
        check("mid_rst_done", 64'(done), 64'd1);
        check("mid_rst_bcd", 64'(bcd), 64'd0);
        check("mid_rst_ndig", 64'(ndig), 64'd0);
        exp_bcd_q.delete();
        exp_ndig_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("mid_rst_no_valid", 64'(n_valid), 64'(nv));
        convert(32'd12345, "post_rst");
        check("post_rst_bcd_const", 64'(bcd), 64'h12345);

        // Chained behind a simple Fibonacci iteration; its completion
        // strobes start for one cycle.
        fa = 32'd0;
        fb = 32'd1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            ft = fa + fb;
            fa = fb;
            fb = ft;
        end
        #1;
        bin   = fa;
        start = 1'b1;
        push_exp(64'd832040);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle("chain");
        @(posedge clk);
        #1;
        check("chain_bcd", 64'(bcd), 64'h0000832040);

        cyc = 0;
        while (exp_bcd_q.size() != 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("queue_drained", 64'(exp_bcd_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fib_bcd.md
# fib_bcd

Sequential binary-to-BCD converter sitting directly downstream of the Fibonacci engine. It captures the engine's `W`-bit binary result (`fibn`) on a start strobe and converts it with shift-add-3 (double dabble), one bit per clock. It presents packed BCD digits plus a significant-digit count for the display/print stage. It uses the same start/done handshake as the engine, so the engine's `done` rising edge can drive `start` directly.

## Interface
- `W`, default 32: binary input width; equals the engine's `w`.
- `DIGITS`, default 10: BCD digit count; must satisfy `DIGITS >= ceil(W*log10(2))`, which gives 10 for `W`=32.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: conversion request; sampled only in IDLE.
- `bin` input W: unsigned binary value; sampled on the accepting edge only.
- `bcd` output 4*DIGITS: packed BCD, digit 0 (units) in bits [3:0]; registered.
- `ndig` output $clog2(DIGITS+1): count of significant decimal digits, 1..DIGITS; registered.
- `valid` output 1: one-cycle pulse when `bcd`/`ndig` are updated.
- `done` output 1: high when idle; low while converting.

## Operation
- States: IDLE and CONV. Counter `cnt` is $clog2(W+1) bits. Registers: binary shift register `sr` (W bits) and scratch `acc` (4*DIGITS bits).
- IDLE with `start`=1 at an edge:
  - `sr`<=`bin`, `acc`<=0, `cnt`<=W; go to CONV.
  - `bcd`/`ndig` keep their previous result.
- IDLE with `start`=0: hold.
- CONV, each edge:
  - Combinationally add 3 to every 4-bit digit of `acc` that is >=5. All digits are adjusted in parallel, before the shift.
  - Shift {adjusted `acc`, `sr`} left by 1: `sr` MSB enters `acc` bit 0, and 0 enters `sr` bit 0.
  - `cnt`<=`cnt`-1.
- CONV edge where `cnt`==1 (the last shift):
  - `bcd`<=final shifted `acc` value.
  - `ndig`<=1+(index of highest nonzero digit of that value), or 1 if all digits are zero.
  - `valid`<=1; go to IDLE.
- `valid` is 0 at every other edge.
- `start` during CONV is ignored: no queueing and no restart.
- `start` held high: a new conversion is accepted on the first IDLE edge, immediately after completion. `valid` and the new accept coincide in that cycle.
- Digit adjustment never overflows 4 bits: a digit is <=9 after every shift, given the `DIGITS` constraint.
- An unreachable state returns to IDLE. It does not halt simulation.

## Timing
- Reset (`rst_n`=0, asynchronous, any state): state=IDLE, `done`=1, `valid`=0, `bcd`=0, `ndig`=0, `sr`=`acc`=`cnt`=0.
  - A reset mid-conversion aborts it, and no `valid` pulse is issued.
  - The first accept can occur on the first rising edge after deassertion.
- `done`=(state==IDLE), decoded from the registered state with no extra delay.
- Accept at edge P0, then `done`=0 from P0 until PW.
- At edge PW (W edges after P0), `bcd`/`ndig` update, and `valid`=1 plus `done`=1 in the cycle after PW.
- Latency: W cycles from accept to result. W+1 cycles per conversion when `start` is held high.
- `bin` may change freely after P0.
- `bcd`/`ndig` are stable from the `valid` cycle until the next completion or reset.

## Test plan
- Reset, then `bin`=832040 (fib(30)), 1-cycle `start` -> `done` low exactly 32 cycles; `bcd`=0x0000832040, `ndig`=6, `valid` high for exactly one cycle.
- `bin`=0 -> `bcd`=0, `ndig`=1. `bin`=4294967295 -> `bcd`=0x4294967295, `ndig`=10 (no digit overflow). `bin`=1 -> `bcd`=1, `ndig`=1.
- During a conversion of 832040, pulse `start` with `bin`=5 at cycles 3 and 20 -> result is still 832040 and the pulses have no effect. `start` after `done` rises converts 5 (`ndig`=1).
- `start` held high with `bin`=100 then `bin`=99 (changed one cycle after accept) -> results 0x100 (`ndig` 3) then 0x99 (`ndig` 2). Accepts are 33 cycles apart, and each `valid` coincides with the next accept.
- Assert `rst_n`=0 mid-cycle at conversion cycle 10 -> `done`=1, `bcd`=0, `ndig`=0 immediately, without a clock edge; no `valid`. A subsequent conversion of 12345 gives `bcd`=0x12345, `ndig`=5.
- Chain with the Fibonacci engine: n=30, engine `done` rising drives `start` -> `bcd`=0x832040.
